// File: rtl/traffic_gen.sv
// traffic_gen: stimulus sequencer for the N-channel FIFO switch.
// Programs the switch thresholds, pulses init, pushes burst_len class-tagged
// words into every input channel (honouring almost_full), waits drain_wait
// cycles, then pops every output until empty or until POP_TIMEOUT expires.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               run request, sampled in IDLE only
//   mode                payload mode: 0 fixed, 1 LFSR, 2 incrementing, 3 as 0
//   burst_len           words per channel
//   drain_wait          idle cycles between PUSH and POP (0 treated as 1)
//   limit_*_cfg         threshold values latched during INIT
//   almost_full         per-input backpressure from the switch
//   empty_out           per-output empty flags from the switch
//   data_in/push/pop    switch data and handshake, channel ch at [ch*DW +: DW]
//   init, limit_*       switch init pulse and thresholds
//   busy, done, err     status: running, end-of-run pulse, pop timeout
//   push_count          saturating count of accepted pushes in this run
module traffic_gen #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DW          = 10,
  parameter int unsigned CLASS_W     = 2,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned LIM_W       = 3,
  parameter int unsigned POP_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     burst_len,
  input  logic [7:0]           drain_wait,
  input  logic [LIM_W-1:0]     limit_low_cfg,
  input  logic [LIM_W-1:0]     limit_high_cfg,
  input  logic [NCH-1:0]       almost_full,
  input  logic [NCH-1:0]       empty_out,
  output logic [NCH*DW-1:0]    data_in,
  output logic [NCH-1:0]       push,
  output logic [NCH-1:0]       pop,
  output logic                 init,
  output logic [LIM_W-1:0]     limit_low,
  output logic [LIM_W-1:0]     limit_high,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          push_count
);

  localparam int unsigned PW   = DW - CLASS_W;
  localparam int unsigned TO_W = $clog2(POP_TIMEOUT + 1);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PUSH, S_WAIT, S_POP, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q [NCH];
  logic [CNT_W-1:0]      cnt_d [NCH];
  logic [15:0]           lfsr_q, lfsr_d;
  logic [7:0]            wait_q, wait_d;
  logic [TO_W-1:0]       tmo_q, tmo_d;
  logic [NCH*DW-1:0]     data_q, data_d;
  logic [NCH-1:0]        push_q, push_d, pop_q, pop_d;
  logic                  init_q, init_d, busy_q, busy_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [LIM_W-1:0]      lim_lo_q, lim_lo_d, lim_hi_q, lim_hi_d;
  logic [15:0]           pcnt_q, pcnt_d;

  logic [16:0]           psum;
  logic                  all_done;
  logic [PW-1:0]         pay;
  logic [CLASS_W-1:0]    cls;
  logic [7:0]            wait_lim;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    wait_d   = wait_q;
    tmo_d    = tmo_q;
    data_d   = data_q;
    push_d   = '0;
    pop_d    = '0;
    err_d    = err_q;
    lim_lo_d = lim_lo_q;
    lim_hi_d = lim_hi_q;
    pcnt_d   = pcnt_q;
    psum     = {1'b0, pcnt_q};
    all_done = 1'b1;
    pay      = '0;
    cls      = '0;
    wait_lim = (drain_wait == 8'd0) ? 8'd1 : drain_wait;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          err_d   = 1'b0;
        end
      end
      S_INIT: begin
        lim_lo_d = limit_low_cfg;
        lim_hi_d = limit_high_cfg;
        for (int unsigned ch = 0; ch < NCH; ch++) cnt_d[ch] = '0;
        pcnt_d   = '0;
        err_d    = 1'b0;
        lfsr_d   = LFSR_SEED;
        wait_d   = '0;
        state_d  = (burst_len == '0) ? S_WAIT : S_PUSH;
      end
      S_PUSH: begin
        lfsr_d = lfsr_step(lfsr_q);
        for (int unsigned ch = 0; ch < NCH; ch++)
          if (cnt_q[ch] < burst_len) all_done = 1'b0;
        // Completion is judged on the counters entering this edge, so a push
        // accepted on this edge is always followed by one more PUSH cycle.
        if (all_done) begin
          state_d = S_WAIT;
        end else begin
          for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (cnt_q[ch] < burst_len && !almost_full[ch]) begin
              case (mode)
                2'd1:    pay = lfsr_q[PW-1:0] ^ PW'(ch);
                2'd2:    pay = PW'(cnt_q[ch]);
                default: pay = PW'(~(16'(ch) * 16'h0011));
              endcase
              cls                 = cnt_q[ch][CLASS_W-1:0];
              push_d[ch]          = 1'b1;
              data_d[ch*DW +: DW] = {cls, pay};
              cnt_d[ch]           = cnt_q[ch] + CNT_W'(1);
              psum                = psum + 17'd1;
            end
          end
          pcnt_d = psum[16] ? 16'hFFFF : psum[15:0];
        end
      end
      S_WAIT: begin
        wait_d = wait_q + 8'd1;
        // pop is launched on the exit edge so the visible push/pop-free gap
        // equals the programmed wait length.
        if (({1'b0, wait_q} + 9'd1) >= {1'b0, wait_lim}) begin
          state_d = S_POP;
          tmo_d   = '0;
          pop_d   = ~empty_out;
        end
      end
      S_POP: begin
        tmo_d = tmo_q + TO_W'(1);
        if (&empty_out) begin
          state_d = S_DONE;
        end else if (tmo_q == TO_W'(POP_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          pop_d = ~empty_out;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    init_d = (state_d == S_INIT);
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '{default: '0};
      lfsr_q   <= LFSR_SEED;
      wait_q   <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      push_q   <= '0;
      pop_q    <= '0;
      init_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      lim_lo_q <= '0;
      lim_hi_q <= '0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      init_q   <= init_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      lim_lo_q <= lim_lo_d;
      lim_hi_q <= lim_hi_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign data_in    = data_q;
  assign push       = push_q;
  assign pop        = pop_q;
  assign init       = init_q;
  assign limit_low  = lim_lo_q;
  assign limit_high = lim_hi_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign push_count = pcnt_q;

endmodule

// File: tb/tb_traffic_gen.sv
// Directed self-checking bench for traffic_gen. A small switch-output model
// holds mw[ch] words per output: empty_out[ch] = (mw[ch]==0), and a word is
// consumed in each cycle that pop[ch] is high.
module tb_traffic_gen;
  localparam int NCH = 4, DW = 10, LIM_W = 3, CNT_W = 5;

  logic               clk = 1'b0;
  logic               reset, start;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   burst_len;
  logic [7:0]         drain_wait;
  logic [LIM_W-1:0]   lo_cfg, hi_cfg;
  logic [NCH-1:0]     almost_full, empty_out;
  logic [NCH*DW-1:0]  data_in;
  logic [NCH-1:0]     push, pop;
  logic               init, busy, done, err;
  logic [LIM_W-1:0]   limit_low, limit_high;
  logic [15:0]        push_count;
  logic [73:0]        all_out;

  int checks = 0;
  int errors = 0;
  int mw [NCH];

  traffic_gen #(.NCH(NCH), .DW(DW), .CLASS_W(2), .CNT_W(CNT_W), .LIM_W(LIM_W),
                .POP_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .burst_len(burst_len),
    .drain_wait(drain_wait), .limit_low_cfg(lo_cfg), .limit_high_cfg(hi_cfg),
    .almost_full(almost_full), .empty_out(empty_out), .data_in(data_in),
    .push(push), .pop(pop), .init(init), .limit_low(limit_low),
    .limit_high(limit_high), .busy(busy), .done(done), .err(err),
    .push_count(push_count)
  );

  assign all_out = {data_in, push, pop, init, limit_low, limit_high, busy, done, err, push_count};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; the output model updates mid-cycle, sampling is #1 after posedge.
  task automatic tick();
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) begin
      if (pop[ch] && mw[ch] > 0) mw[ch]--;
      empty_out[ch] = (mw[ch] == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m, input int bl, input int dw);
    mode = m; burst_len = CNT_W'(bl); drain_wait = 8'(dw);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int limit, output bit seen, output int pushes);
    seen = 1'b0; pushes = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (push != 0) pushes++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    reset = 1'b0;
    tick();
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_idle: got %h expected 0", all_out); end
  endtask

  task automatic test_basic();
    logic [7:0] pay [NCH] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
    bit seen; int np;
    lo_cfg = 3'd2; hi_cfg = 3'd5;
    start_run(2'd0, 4, 3);
    checks++;
    if (init !== 1'b1 || busy !== 1'b1 || push !== '0) begin
      errors++; $display("FAIL basic_init: init=%b busy=%b push=%h expected 1 1 0", init, busy, push);
    end
    tick();
    checks++;
    if (init !== 1'b0 || limit_low !== 3'd2 || limit_high !== 3'd5) begin
      errors++; $display("FAIL basic_limits: init=%b lo=%0d hi=%0d expected 0 2 5", init, limit_low, limit_high);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (push !== 4'hF) begin errors++; $display("FAIL basic_push%0d: got %h expected f", k, push); end
      for (int ch = 0; ch < NCH; ch++) begin
        checks++;
        if (data_in[ch*DW +: DW] !== {2'(k), pay[ch]}) begin
          errors++; $display("FAIL basic_data ch%0d w%0d: got %h expected %h", ch, k, data_in[ch*DW +: DW], {2'(k), pay[ch]});
        end
      end
    end
    tick();
    checks++;
    if (push !== '0 || push_count !== 16'd16) begin
      errors++; $display("FAIL basic_end: push=%h count=%0d expected 0 16", push, push_count);
    end
    run_until_done(50, seen, np);
    checks++;
    if (!seen || err !== 1'b0 || push_count !== 16'd16) begin
      errors++; $display("FAIL basic_done: seen=%b err=%b count=%0d expected 1 0 16", seen, err, push_count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_push [10] = '{4'hF, 4'hB, 4'hB, 4'hB, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
    int active = 0; bit seen; int np;
    start_run(2'd0, 4, 3);
    tick();
    for (int i = 1; i <= 10; i++) begin
      almost_full = (i >= 2 && i <= 4) ? 4'b0100 : 4'b0000;
      start = (i == 3);  // must be ignored outside IDLE
      tick();
      if (push != 0) active++;
      checks++;
      if (push !== exp_push[i-1]) begin
        errors++; $display("FAIL bp_push c%0d: got %h expected %h", i, push, exp_push[i-1]);
      end
      if (i == 5 || i == 7) begin
        checks++;
        if (data_in[2*DW +: DW] !== {2'(i - 4), 8'hDD}) begin
          errors++; $display("FAIL bp_data c%0d: got %h expected %h", i, data_in[2*DW +: DW], {2'(i - 4), 8'hDD});
        end
      end
    end
    almost_full = '0; start = 1'b0;
    checks++;
    if (active != 7 || push_count !== 16'd16) begin
      errors++; $display("FAIL bp_len: cycles=%0d count=%0d expected 7 16", active, push_count);
    end
    run_until_done(50, seen, np);
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_done: got 0 expected 1"); end
    tick();
  endtask

  task automatic test_drain();
    int idle = 0, popc = 0;
    for (int ch = 0; ch < NCH; ch++) mw[ch] = 4;
    start_run(2'd0, 4, 90);
    tick();
    repeat (4) tick();
    tick();
    checks++;
    if (push !== '0 || pop !== '0) begin errors++; $display("FAIL drain_start: push=%h pop=%h expected 0 0", push, pop); end
    idle = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (pop !== '0 || push !== '0) break;
      idle++;
    end
    checks++;
    if (idle != 90) begin errors++; $display("FAIL drain_idle: got %0d expected 90", idle); end
    for (int i = 0; i < 20; i++) begin
      if (pop !== 4'hF) break;
      popc++;
      tick();
    end
    checks++;
    if (popc != 4) begin errors++; $display("FAIL drain_pops: got %0d expected 4", popc); end
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || pop !== '0) begin
      errors++; $display("FAIL drain_done: done=%b err=%b pop=%h expected 1 0 0", done, err, pop);
    end
    tick();
  endtask

  task automatic test_timeout();
    int popc = 0;
    mw[0] = 0; mw[1] = 1000; mw[2] = 0; mw[3] = 0;
    start_run(2'd0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pop !== '0) break;
    end
    for (int i = 0; i < 400; i++) begin
      if (pop !== 4'b0010) break;
      popc++;
      tick();
    end
    checks++;
    if (popc != 255) begin errors++; $display("FAIL timeout_pops: got %0d expected 255", popc); end
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || pop !== '0) begin
      errors++; $display("FAIL timeout_done: done=%b err=%b pop=%h expected 1 1 0", done, err, pop);
    end
    tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_hold: err=%b busy=%b expected 1 0", err, busy); end
    mw[1] = 0;
  endtask

  task automatic test_zero_burst();
    bit seen; int np;
    start_run(2'd0, 0, 2);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL zero_errclr: got %b expected 0", err); end
    run_until_done(50, seen, np);
    checks++;
    if (!seen || np != 0 || push_count !== 16'd0) begin
      errors++; $display("FAIL zero_burst: seen=%b pushes=%0d count=%0d expected 1 0 0", seen, np, push_count);
    end
    tick();
  endtask

  task automatic test_lfsr();
    logic [9:0] e0 [3] = '{10'h0E1, 10'h170, 10'h238};
    logic [9:0] e1 [3] = '{10'h0E0, 10'h171, 10'h239};
    bit seen; int np;
    start_run(2'd1, 3, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (data_in[0 +: DW] !== e0[k] || data_in[DW +: DW] !== e1[k]) begin
        errors++; $display("FAIL lfsr_w%0d: ch0=%h ch1=%h expected %h %h", k, data_in[0 +: DW], data_in[DW +: DW], e0[k], e1[k]);
      end
    end
    run_until_done(50, seen, np);
    checks++;
    if (!seen || push_count !== 16'd12) begin errors++; $display("FAIL lfsr_count: seen=%b count=%0d expected 1 12", seen, push_count); end
    tick();
  endtask

  task automatic test_incr();
    logic [9:0] e [3] = '{10'h000, 10'h101, 10'h202};
    bit seen; int np;
    start_run(2'd2, 3, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (data_in[3*DW +: DW] !== e[k]) begin
        errors++; $display("FAIL incr_w%0d: got %h expected %h", k, data_in[3*DW +: DW], e[k]);
      end
    end
    run_until_done(50, seen, np);
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen; int np;
    start_run(2'd0, 8, 1);
    tick();
    repeat (2) tick();
    checks++;
    if (push !== 4'hF) begin errors++; $display("FAIL mid_push: got %h expected f", push); end
    reset = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL mid_reset: got %h expected 0", all_out); end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || all_out !== '0) begin errors++; $display("FAIL mid_idle: busy=%b out=%h expected 0 0", busy, all_out); end
    start_run(2'd0, 8, 1);
    checks++;
    if (init !== 1'b1) begin errors++; $display("FAIL mid_restart: init=%b expected 1", init); end
    run_until_done(100, seen, np);
    checks++;
    if (!seen || push_count !== 16'd32) begin errors++; $display("FAIL mid_done: seen=%b count=%0d expected 1 32", seen, push_count); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = '0; burst_len = '0; drain_wait = '0;
    lo_cfg = '0; hi_cfg = '0; almost_full = '0; empty_out = '1;
    for (int ch = 0; ch < NCH; ch++) mw[ch] = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_drain();
    test_timeout();
    test_zero_burst();
    test_lfsr();
    test_incr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_gen.md
Name: traffic_gen

Overview:
- Synthesizable, parametrised stimulus sequencer for the N-channel FIFO switch.
- Programs the switch thresholds, pulses init, and pushes a configurable burst of class-tagged words into every input channel.
- Honours per-channel almost-full backpressure, waits a programmable drain time, then pops each output until empty.
- Replaces hand-timed bench stimulus; usable in simulation and on FPGA.

Parameters:
- NCH, 4, number of input and output channels.
- DW, 10, word width; the top CLASS_W bits are the destination class, the rest is payload (PW = DW-CLASS_W).
- CLASS_W, 2, class field width.
- CNT_W, 5, width of burst_len and the per-channel word counters.
- LIM_W, 3, width of the threshold registers.
- POP_TIMEOUT, 255, maximum POP-state cycles before aborting with an error.

Ports:
- clk  in  1  single clock, all activity on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to run a sequence; sampled in IDLE only.
- mode  in  2  payload mode: 0 fixed, 1 LFSR, 2 incrementing, 3 reserved (treated as 0).
- burst_len  in  CNT_W  words per channel.
- drain_wait  in  8  idle cycles between PUSH and POP.
- limit_low_cfg  in  LIM_W  value for limit_low.
- limit_high_cfg  in  LIM_W  value for limit_high.
- almost_full  in  NCH  per-input backpressure from the switch.
- empty_out  in  NCH  per-output empty flags from the switch.
- data_in  out  NCH*DW  channel ch occupies bits [ch*DW +: DW].
- push  out  NCH  per-channel push.
- pop  out  NCH  per-channel pop.
- init  out  1  switch init pulse.
- limit_low  out  LIM_W  threshold to switch.
- limit_high  out  LIM_W  threshold to switch.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  set on pop timeout; cleared on the next start.
- push_count  out  16  total accepted pushes in the current run.

Behaviour:
- All outputs are registered.
- Reset state: IDLE, and every output is 0, including data_in, limits, err and push_count. The LFSR is loaded with 16'hACE1. Reset mid-sequence aborts immediately to this state.
- IDLE: on start, go to INIT. start is ignored in every other state.
- INIT (exactly 1 cycle):
  - init=1.
  - limit_low/limit_high latch the cfg inputs and hold until the next INIT.
  - Per-channel word counters, push_count and err clear; LFSR reloads 16'hACE1.
  - Next state is PUSH, or WAIT if burst_len==0.
- PUSH, at each posedge, for each ch:
  - If cnt[ch] < burst_len and almost_full[ch]==0: push[ch]<=1, data_in[ch] <= {class, payload}, cnt[ch]++, and push_count is incremented.
  - Otherwise push[ch]<=0 and data_in[ch] holds its value.
  - The class field is cnt[ch] modulo 2^CLASS_W.
  - Payload, mode 0: low PW bits of ~(ch*8'h11), giving FF, EE, DD, CC for PW=8.
  - Payload, mode 1: lfsr[PW-1:0] XOR ch. The LFSR is a Galois 16-bit with taps 16'hB400 and advances once per PUSH cycle.
  - Payload, mode 2: cnt[ch].
  - A stalled channel does not advance its counter; other channels continue independently.
  - When every cnt[ch]==burst_len, push<=0 on that edge and go to WAIT.
- WAIT: max(drain_wait,1) cycles with push=pop=0, then go to POP with the timeout counter cleared.
- POP, each posedge:
  - pop[ch] <= ~empty_out[ch].
  - When all empty_out are 1, pop<=0 and go to DONE.
  - If POP_TIMEOUT cycles elapse first, pop<=0, err<=1, and go to DONE.
- DONE: done=1 for 1 cycle, then IDLE. push_count, err and limits hold.
- push_count saturates at 16'hFFFF.
- Simultaneous almost_full deassert and counter completion on the same edge: the push happens, and completion is then evaluated on the following edge.

Test Plan:
- Reset held 5 cycles mid-PUSH, then released -> all outputs 0 in the first cycle after reset, state IDLE, start required to restart.
- mode=0, burst_len=4, almost_full=0 -> init 1 cycle, then 4 consecutive push cycles on all 4 channels with ch0 data 0x0FF,0x1FF,0x2FF,0x3FF and ch3 data 0x0CC..0x3CC; push_count=16.
- Backpressure: same config, almost_full[2]=1 for 3 cycles from the 2nd push cycle -> ch2 pushes 4 words with a 3-cycle gap, other channels unaffected; PUSH lasts 7 cycles.
- Drain: drain_wait=90, the switch model holds 4 words per output -> exactly 90 idle cycles, then pop high 4 cycles per channel, done pulse, err=0.
- Timeout: POP_TIMEOUT=255, empty_out[1] stuck 0 -> pop[1] high 255 cycles, then err=1, done pulses, pop=0.
- burst_len=0 and mode=1 with burst_len=3 -> the zero case skips PUSH (push never asserted); the LFSR case gives ch0 payloads matching the 0xACE1-seeded reference sequence, ch1 = ch0 XOR 1.
